// File: rtl/katio_logic_gates.sv
// katio_logic_gates
//   Registered two-operand bitwise logic unit. Produces AND, XOR and NAND of
//   two WIDTH-bit operands in parallel with one cycle of latency. The ALU
//   result mux selects among these outputs.
//
//   Optional feature macro: KATIO_GATES_DIFF_EN
//     When defined, adds diff_cnt, the registered popcount of a ^ b
//     (Hamming distance between the operands).
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     in_valid   qualifies a/b for capture this cycle
//     a, b       WIDTH-bit operands
//     and_out    registered a & b
//     exor_out   registered a ^ b
//     nand_out   registered ~(a & b)
//     out_valid  one-cycle pulse per captured input
//     diff_cnt   registered popcount(a ^ b), $clog2(WIDTH+1) bits (macro only)

// One bit lane. Bits never interact, so the datapath is just WIDTH copies.
module katio_gate_lane (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic and_q,
    output logic exor_q,
    output logic nand_q
);
    // nand_q is its own flop (reset to 1) rather than an inverter on and_q,
    // so every output comes straight off a register; it always equals ~and_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_q  <= 1'b0;
            exor_q <= 1'b0;
            nand_q <= 1'b1;
        end else if (en) begin
            and_q  <= a & b;
            exor_q <= a ^ b;
            nand_q <= ~(a & b);
        end
    end
endmodule

module katio_logic_gates #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] exor_out,
    output logic [WIDTH-1:0] nand_out,
`ifdef KATIO_GATES_DIFF_EN
    output logic [$clog2(WIDTH+1)-1:0] diff_cnt,
`endif
    output logic             out_valid
);
    localparam int STAGES = 1;

    // vld_pipe[0] is the incoming strobe; higher taps are registered copies.
    logic [STAGES:0] vld_pipe;
    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign out_valid = vld_pipe[STAGES];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        katio_gate_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (in_valid),
            .a      (a[i]),
            .b      (b[i]),
            .and_q  (and_out[i]),
            .exor_q (exor_out[i]),
            .nand_q (nand_out[i])
        );
    end

`ifdef KATIO_GATES_DIFF_EN
    localparam int CNT_W = $clog2(WIDTH+1);

    logic [CNT_W-1:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + CNT_W'(a[i] ^ b[i]);
    end

    // Same capture/hold/reset rules as the gate outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           diff_cnt <= '0;
        else if (in_valid) diff_cnt <= pop;
    end
`endif
endmodule

// File: tb/tb_katio_logic_gates.sv
module tb_katio_logic_gates;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_run = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [7:0] a8 = '0, b8 = '0;

    logic [0:0] and1, xor1, nand1;
    logic [7:0] and8, xor8, nand8;
    logic       ov1, ov8;
`ifdef KATIO_GATES_DIFF_EN
    logic [0:0] cnt1;
    logic [3:0] cnt8;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state: what the outputs must show after the last edge.
    logic [7:0] m_and8, m_xor8, m_nand8;
    logic [0:0] m_and1, m_xor1, m_nand1;
    int         m_cnt8, m_cnt1;
    logic       m_vld;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    katio_logic_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
        .and_out(and1), .exor_out(xor1), .nand_out(nand1),
`ifdef KATIO_GATES_DIFF_EN
        .diff_cnt(cnt1),
`endif
        .out_valid(ov1)
    );

    katio_logic_gates #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
        .and_out(and8), .exor_out(xor8), .nand_out(nand8),
`ifdef KATIO_GATES_DIFF_EN
        .diff_cnt(cnt8),
`endif
        .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_and8 = 8'h00; m_xor8 = 8'h00; m_nand8 = 8'hFF; m_cnt8 = 0;
        m_and1 = 1'b0;  m_xor1 = 1'b0;  m_nand1 = 1'b1;  m_cnt1 = 0;
        m_vld  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, " and8"},  64'(and8),  64'(m_and8));
        chk({tag, " xor8"},  64'(xor8),  64'(m_xor8));
        chk({tag, " nand8"}, 64'(nand8), 64'(m_nand8));
        chk({tag, " vld8"},  64'(ov8),   64'(m_vld));
        chk({tag, " and1"},  64'(and1),  64'(m_and1));
        chk({tag, " xor1"},  64'(xor1),  64'(m_xor1));
        chk({tag, " nand1"}, 64'(nand1), 64'(m_nand1));
        chk({tag, " vld1"},  64'(ov1),   64'(m_vld));
`ifdef KATIO_GATES_DIFF_EN
        chk({tag, " cnt8"},  64'(cnt8),  64'(m_cnt8));
        chk({tag, " cnt1"},  64'(cnt1),  64'(m_cnt1));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, update reference, check.
    task automatic cycle(input string tag, input logic v, input logic [7:0] va8,
                         input logic [7:0] vb8, input logic va1, input logic vb1);
        in_valid = v; a8 = va8; b8 = vb8; a1 = va1; b1 = vb1;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            if (v) begin
                m_and8 = va8 & vb8; m_xor8 = va8 ^ vb8; m_nand8 = ~(va8 & vb8);
                m_cnt8 = $countones(va8 ^ vb8);
                m_and1 = va1 & vb1; m_xor1 = va1 ^ vb1; m_nand1 = ~(va1 & vb1);
                m_cnt1 = (va1 != vb1) ? 1 : 0;
            end
            m_vld = v;
        end
        check_all(tag);
    endtask

    initial begin
        // Reset with clock stopped: values appear immediately.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("por");

        clk_run = 1'b1;
        cycle("rst_hold", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        rst = 1'b0;

        // WIDTH=1 truth table on consecutive cycles.
        cycle("tt00", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle("tt10", 1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
        cycle("tt01", 1'b1, 8'h56, 8'h78, 1'b0, 1'b1);
        cycle("tt11", 1'b1, 8'h9A, 8'hBC, 1'b1, 1'b1);
        chk("tt11 and1 const", 64'(and1), 64'd1);
        chk("tt11 nand1 const", 64'(nand1), 64'd0);

        // Hold: capture then drop in_valid and wiggle inputs.
        cycle("hold_cap", 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b1);
        cycle("hold1", 1'b0, 8'h0F, 8'hC3, 1'b1, 1'b1);
        cycle("hold2", 1'b0, 8'hAA, 8'h55, 1'b1, 1'b0);
        chk("hold and const",  64'(and8),  64'h30);
        chk("hold xor const",  64'(xor8),  64'hCC);
        chk("hold nand const", 64'(nand8), 64'hCF);

        // Back-to-back.
        cycle("b2b_1", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        cycle("b2b_2", 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
        chk("b2b nand const", 64'(nand8), 64'hFF);

        // Hamming distance patterns.
        cycle("diff_a5", 1'b1, 8'hA5, 8'h0F, 1'b1, 1'b0);
        chk("diff xor const", 64'(xor8), 64'hAA);
        cycle("diff_eq", 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0);

        // Reset with clock stopped after non-reset outputs.
        cycle("pre_rst", 1'b1, 8'hC3, 8'h81, 1'b1, 1'b1);
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
        clk_run = 1'b1;

        // Reset during an in_valid cycle loses the capture.
        cycle("warm", 1'b1, 8'h3C, 8'h0F, 1'b1, 1'b0);
        rst = 1'b1;
        cycle("rst_act", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        rst = 1'b0;
        cycle("post_rst", 1'b1, 8'h6E, 8'hB3, 1'b1, 1'b1);

        // Randomized traffic with mixed valid.
        for (int i = 0; i < 60; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
